// File: rtl/nb_force_accumulator.sv
// nb_force_accumulator
// Per-atom Q16.16 force bank fed by the non-bonded pair pipeline. Each
// accepted pair adds its force into atom i with saturation; a small
// controller clears the bank one slot per cycle or streams it out over a
// valid/ready port.
// Optional feature macro: NEWTON3_EN -- when defined, the negated force is
// also written into atom j in the same cycle, j is range-checked and i == j
// pairs are treated as a net-zero no-op.

module nb_force_accumulator #(
   parameter int N_ATOMS = 16,
   parameter int IDX_W   = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_start,
   input  logic             dump_start,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_idx_i,
   input  logic [IDX_W-1:0] in_idx_j,
   input  logic [31:0]      in_fx,
   input  logic [31:0]      in_fy,
   input  logic [31:0]      in_fz,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [31:0]      out_fx,
   output logic [31:0]      out_fy,
   output logic [31:0]      out_fz,
   output logic             out_last,
   output logic             sat_flag,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DUMP  = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ATOMS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [31:0]      acc_q [N_ATOMS][3];
   logic [31:0]      acc_d [N_ATOMS][3];
   logic             sat_q, sat_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic [31:0]      f_in [3];
   logic [32:0]      sum_i [3];
   logic             i_ok;
   logic             j_ok;
   logic             same_ij;
   logic             drop_inc;

   // Saturating 32-bit add/subtract; bit 32 of the result flags a clamp.
   function automatic logic [32:0] sat_sum(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sub);
      logic [32:0] s;
      if (sub) begin
         s = {a[31], a} - {b[31], b};
      end else begin
         s = {a[31], a} + {b[31], b};
      end
      if (s[32] != s[31]) begin
         sat_sum = {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
      end else begin
         sat_sum = {1'b0, s[31:0]};
      end
   endfunction

   assign f_in[0] = in_fx;
   assign f_in[1] = in_fy;
   assign f_in[2] = in_fz;

   assign i_ok = (32'(in_idx_i) < N_ATOMS);

`ifdef NEWTON3_EN
   logic [32:0] sum_j [3];

   assign j_ok    = (32'(in_idx_j) < N_ATOMS);
   assign same_ij = (in_idx_i == in_idx_j);

   // Reaction force: current bank value of atom j minus the pair force.
   always_comb begin
      for (int a = 0; a < 3; a++) begin
         sum_j[a] = sat_sum(acc_q[in_idx_j][a], f_in[a], 1'b1);
      end
   end
`else
   logic unused_idx_j;

   assign j_ok         = 1'b1;
   assign same_ij      = 1'b0;
   assign unused_idx_j = ^in_idx_j;
`endif

   // Action force: current bank value of atom i plus the pair force.
   always_comb begin
      for (int a = 0; a < 3; a++) begin
         sum_i[a] = sat_sum(acc_q[in_idx_i][a], f_in[a], 1'b0);
      end
   end

   // Next-state logic: FSM, bank updates, clear sweep, dump pointer, flags.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      acc_d    = acc_q;
      sat_d    = sat_q;
      drop_d   = drop_q;
      drop_inc = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (!(i_ok && j_ok)) begin
                  drop_inc = 1'b1;
               end else if (!same_ij) begin
                  for (int a = 0; a < 3; a++) begin
                     acc_d[in_idx_i][a] = sum_i[a][31:0];
                     sat_d = sat_d | sum_i[a][32];
`ifdef NEWTON3_EN
                     acc_d[in_idx_j][a] = sum_j[a][31:0];
                     sat_d = sat_d | sum_j[a][32];
`endif
                  end
               end
            end
            if (clear_start) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
            end else if (dump_start) begin
               state_d = S_DUMP;
               ptr_d   = '0;
            end
         end

         S_CLEAR: begin
            if (in_valid) begin
               drop_inc = 1'b1;
            end
            for (int a = 0; a < 3; a++) begin
               acc_d[ptr_q][a] = '0;
            end
            if (ptr_q == LAST_IDX) begin
               state_d = S_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end

         S_DUMP: begin
            if (in_valid) begin
               drop_inc = 1'b1;
            end
            if (out_ready) begin
               if (ptr_q == LAST_IDX) begin
                  state_d = S_IDLE;
                  ptr_d   = '0;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            ptr_d   = '0;
         end
      endcase

      if (drop_inc && (drop_d != CNT_MAX)) begin
         drop_d = drop_d + 1'b1;
      end

      // Entering CLEAR wipes the sticky flags, overriding anything above.
      if ((state_q == S_IDLE) && clear_start) begin
         sat_d  = 1'b0;
         drop_d = '0;
      end
   end

   // Control registers: FSM state, shared clear/dump pointer, flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         sat_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sat_q   <= sat_d;
         drop_q  <= drop_d;
      end
   end

   // Force bank registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < N_ATOMS; n++) begin
            for (int a = 0; a < 3; a++) begin
               acc_q[n][a] <= '0;
            end
         end
      end else begin
         for (int n = 0; n < N_ATOMS; n++) begin
            for (int a = 0; a < 3; a++) begin
               acc_q[n][a] <= acc_d[n][a];
            end
         end
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DUMP);
   assign out_idx   = ptr_q;
   assign out_fx    = out_valid ? acc_q[ptr_q][0] : 32'h0;
   assign out_fy    = out_valid ? acc_q[ptr_q][1] : 32'h0;
   assign out_fz    = out_valid ? acc_q[ptr_q][2] : 32'h0;
   assign out_last  = out_valid && (ptr_q == LAST_IDX);
   assign sat_flag  = sat_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_nb_force_accumulator.sv
// tb_nb_force_accumulator
// Directed bench for nb_force_accumulator with hand-computed bank contents.
// Expectations for the reaction-force path follow the NEWTON3_EN macro.

module tb_nb_force_accumulator;

   localparam int N_ATOMS = 16;
   localparam int IDX_W   = 4;
   localparam int CNT_W   = 16;

   logic             clk;
   logic             rst_n;
   logic             clear_start;
   logic             dump_start;
   logic             in_valid;
   logic [IDX_W-1:0] in_idx_i;
   logic [IDX_W-1:0] in_idx_j;
   logic [31:0]      in_fx;
   logic [31:0]      in_fy;
   logic [31:0]      in_fz;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic [31:0]      out_fx;
   logic [31:0]      out_fy;
   logic [31:0]      out_fz;
   logic             out_last;
   logic             sat_flag;
   logic [CNT_W-1:0] drop_cnt;

   int numChecks;
   int numFails;

   logic [31:0] mx [N_ATOMS];
   logic [31:0] my [N_ATOMS];
   logic [31:0] mz [N_ATOMS];
   logic [31:0] dx [N_ATOMS];
   logic [31:0] dy [N_ATOMS];
   logic [31:0] dz [N_ATOMS];

   nb_force_accumulator #(
      .N_ATOMS(N_ATOMS),
      .IDX_W  (IDX_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_start(clear_start),
      .dump_start (dump_start),
      .in_valid   (in_valid),
      .in_idx_i   (in_idx_i),
      .in_idx_j   (in_idx_j),
      .in_fx      (in_fx),
      .in_fy      (in_fy),
      .in_fz      (in_fz),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_fx     (out_fx),
      .out_fy     (out_fy),
      .out_fz     (out_fz),
      .out_last   (out_last),
      .sat_flag   (sat_flag),
      .drop_cnt   (drop_cnt)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      numChecks++;
      if (obs !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clearModel();
      for (int k = 0; k < N_ATOMS; k++) begin
         mx[k] = '0;
         my[k] = '0;
         mz[k] = '0;
      end
   endtask

   // Hold one pair on the input for cnt consecutive cycles.
   task automatic applyStimulus(input int i, input int j, input logic [31:0] fx,
                                input logic [31:0] fy, input logic [31:0] fz, input int cnt);
      @(negedge clk);
      in_valid = 1'b1;
      in_idx_i = IDX_W'(i);
      in_idx_j = IDX_W'(j);
      in_fx    = fx;
      in_fy    = fy;
      in_fz    = fz;
      repeat (cnt) @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Stream the bank out; optionally toggle out_ready and inject a pair mid-dump.
   task automatic runDump(input bit toggle, input bit inject);
      int beat;
      int cycles;
      bit stalled;
      logic [IDX_W-1:0] heldIdx;
      logic [31:0] heldFx;
      logic [31:0] heldFz;
      beat = 0;
      cycles = 0;
      stalled = 0;
      heldIdx = '0;
      heldFx = '0;
      heldFz = '0;
      @(negedge clk);
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      checkOutput("dump_first_valid", 32'(out_valid), 32'd1);
      while (beat < N_ATOMS && cycles < 200) begin
         if (stalled) begin
            checkOutput("stall_idx", 32'(out_idx), 32'(heldIdx));
            checkOutput("stall_fx", out_fx, heldFx);
            checkOutput("stall_fz", out_fz, heldFz);
         end
         out_ready = toggle ? ((cycles % 2) == 1) : 1'b1;
         if (inject && cycles == 3) begin
            in_valid = 1'b1;
            in_idx_i = 4'd15;
            in_idx_j = 4'd0;
            in_fx    = 32'h0000_0007;
            in_fy    = 32'h0000_0007;
            in_fz    = 32'h0000_0007;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid && out_ready) begin
            checkOutput("beat_idx", 32'(out_idx), 32'(beat));
            checkOutput("beat_last", 32'(out_last), 32'(beat == N_ATOMS - 1));
            dx[beat] = out_fx;
            dy[beat] = out_fy;
            dz[beat] = out_fz;
            beat++;
            stalled = 0;
         end else if (out_valid) begin
            stalled = 1;
            heldIdx = out_idx;
            heldFx = out_fx;
            heldFz = out_fz;
         end
         cycles++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (beat < N_ATOMS) begin
         checkOutput("dump_timeout", 32'(beat), 32'(N_ATOMS));
      end
      checkOutput("dump_end_valid", 32'(out_valid), 32'd0);
      checkOutput("dump_end_busy", 32'(busy), 32'd0);
   endtask

   // Compare the last dump against the hand-computed model.
   task automatic compareBank(input string tag);
      for (int k = 0; k < N_ATOMS; k++) begin
         checkOutput($sformatf("%s_x%0d", tag, k), dx[k], mx[k]);
         checkOutput($sformatf("%s_y%0d", tag, k), dy[k], my[k]);
         checkOutput($sformatf("%s_z%0d", tag, k), dz[k], mz[k]);
      end
   endtask

   // Pulse clear_start and count the busy cycles that follow.
   task automatic runClear();
      int cnt;
      cnt = 0;
      @(negedge clk);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      checkOutput("clear_cycles", 32'(cnt), 32'(N_ATOMS));
      checkOutput("clear_sat", 32'(sat_flag), 32'd0);
      checkOutput("clear_drop", 32'(drop_cnt), 32'd0);
      clearModel();
   endtask

   // Main directed sequence.
   initial begin
      int waitCnt;
      numChecks   = 0;
      numFails    = 0;
      rst_n       = 1'b0;
      clear_start = 1'b0;
      dump_start  = 1'b0;
      in_valid    = 1'b0;
      in_idx_i    = '0;
      in_idx_j    = '0;
      in_fx       = '0;
      in_fy       = '0;
      in_fz       = '0;
      out_ready   = 1'b1;
      clearModel();

      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_idx", 32'(out_idx), 32'd0);
      checkOutput("rst_fx", out_fx, 32'd0);
      checkOutput("rst_last", 32'(out_last), 32'd0);
      checkOutput("rst_sat", 32'(sat_flag), 32'd0);
      checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
      rst_n = 1'b1;

      $display("[TB] dump after reset");
      runDump(1'b0, 1'b0);
      compareBank("zero");
      checkOutput("zero_sat", 32'(sat_flag), 32'd0);

      $display("[TB] single pairs");
      applyStimulus(2, 5, 32'h0001_8000, 32'hFFFF_0000, 32'h0000_4000, 1);
      applyStimulus(4, 4, 32'h0001_0000, 32'h0, 32'h0, 1);
      applyStimulus(15, 0, 32'h0002_0000, 32'h0, 32'h0, 1);
      mx[2] = 32'h0001_8000;
      my[2] = 32'hFFFF_0000;
      mz[2] = 32'h0000_4000;
      mx[15] = 32'h0002_0000;
`ifdef NEWTON3_EN
      mx[5] = 32'hFFFE_8000;
      my[5] = 32'h0001_0000;
      mz[5] = 32'hFFFF_C000;
      mx[0] = 32'hFFFE_0000;
`else
      mx[4] = 32'h0001_0000;
`endif
      runDump(1'b0, 1'b0);
      compareBank("pairs");
      checkOutput("pairs_sat", 32'(sat_flag), 32'd0);
      checkOutput("pairs_drop", 32'(drop_cnt), 32'd0);

      $display("[TB] clear then back-to-back");
      runClear();
      applyStimulus(2, 5, 32'h0001_0000, 32'h0, 32'h0, 4);
      mx[2] = 32'h0004_0000;
`ifdef NEWTON3_EN
      mx[5] = 32'hFFFC_0000;
`endif
      runDump(1'b0, 1'b0);
      compareBank("b2b");

      $display("[TB] saturation");
      applyStimulus(1, 6, 32'h7000_0000, 32'h0, 32'h0, 2);
      applyStimulus(3, 7, 32'h8000_0000, 32'h0, 32'h0, 2);
      mx[1] = 32'h7FFF_FFFF;
      mx[3] = 32'h8000_0000;
`ifdef NEWTON3_EN
      mx[6] = 32'h8000_0000;
      mx[7] = 32'h7FFF_FFFF;
`endif
      @(negedge clk);
      checkOutput("sat_set", 32'(sat_flag), 32'd1);

      $display("[TB] stalled dump with dropped pair");
      runDump(1'b1, 1'b1);
      compareBank("stall");
      checkOutput("stall_drop", 32'(drop_cnt), 32'd1);
      checkOutput("stall_sat", 32'(sat_flag), 32'd1);

      runClear();
      runDump(1'b0, 1'b0);
      compareBank("cleared");

      $display("[TB] reset mid-dump");
      applyStimulus(9, 10, 32'h1234_5678, 32'h0000_0001, 32'h0, 1);
      @(negedge clk);
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      waitCnt = 0;
      while (out_idx != 4'd7 && waitCnt < 100) begin
         waitCnt++;
         @(negedge clk);
      end
      checkOutput("reach_beat7", 32'(out_idx), 32'd7);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", 32'(out_valid), 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_idx", 32'(out_idx), 32'd0);
      checkOutput("arst_last", 32'(out_last), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clearModel();
      runDump(1'b0, 1'b0);
      compareBank("arst");
      checkOutput("arst_drop", 32'(drop_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/nb_force_accumulator.md
# nb_force_accumulator

Per-atom force accumulator downstream of the non-bonded pair pipeline. Each valid pair result (Q16.16 force on atom i from atom j) is added into an on-chip per-atom force bank. With Newton's-third-law mode compiled in, the negated force is also applied to atom j. A small controller clears the bank and streams final per-atom forces out to the integrator over a valid/ready port.

## Interface
Parameters:
- N_ATOMS, 16, number of atom slots in the force bank
- IDX_W, 4, atom index width; N_ATOMS <= 2^IDX_W
- CNT_W, 16, width of the dropped-pair counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- clear_start  in  1  pulse: zero the bank and flags (sampled in IDLE only)
- dump_start  in  1  pulse: stream the bank out (sampled in IDLE only)
- in_valid  in  1  pair result valid; driven by the pair pipeline's valid_out
- in_idx_i  in  IDX_W  index of atom i
- in_idx_j  in  IDX_W  index of atom j
- in_fx, in_fy, in_fz  in  32 each  signed Q16.16 force on atom i
- busy  out  1  high in CLEAR or DUMP
- out_valid  out  1  dump beat valid
- out_ready  in  1  downstream accepts beat
- out_idx  out  IDX_W  atom index of current beat
- out_fx, out_fy, out_fz  out  32 each  signed Q16.16 accumulated force
- out_last  out  1  high on beat for index N_ATOMS-1
- sat_flag  out  1  sticky: any accumulation saturated
- drop_cnt  out  CNT_W  pairs discarded (not in IDLE or index out of range)

## Operation
- Bank: N_ATOMS x 3 x 32-bit signed registers, async reset to 0.
- FSM states IDLE, CLEAR, DUMP; reset state IDLE.
- IDLE: in_valid pair accepted. Per axis: acc[i] <= sat(acc[i] + f). With NEWTON3_EN: acc[j] <= sat(acc[j] - f) in the same cycle (two writes per cycle).
- i == j with NEWTON3_EN: net-zero, no bank change, no saturation check, not counted as dropped.
- Index >= N_ATOMS on either i or (with NEWTON3_EN) j: entire pair discarded, drop_cnt += 1.
- Saturation: sum computed at 33 bits, clamped to [-2^31, 2^31-1]; any clamp sets sat_flag.
- IDLE + clear_start -> CLEAR (clear_start wins if both starts high). IDLE + dump_start -> DUMP.
- CLEAR: zero one atom slot per cycle, index 0..N_ATOMS-1; sat_flag and drop_cnt cleared on entry; return to IDLE after last slot.
- DUMP: out_valid high, out_idx starts at 0; data = acc[out_idx]. Beat advances on out_valid & out_ready; after out_last beat handshakes, return to IDLE. Dump is non-destructive.
- in_valid during CLEAR or DUMP: pair discarded, drop_cnt += 1.
- drop_cnt saturates at 2^CNT_W-1.
- starts outside IDLE ignored.

## Timing
- Reset values: busy 0, out_valid 0, out_idx 0, out_fx/fy/fz 0, out_last 0, sat_flag 0, drop_cnt 0.
- Accumulation latency 1 cycle: update visible in bank (and to a dump started after) the cycle after in_valid.
- Back-to-back pairs to same atom every cycle accumulate correctly (single-cycle RMW, no hazard stall; no input backpressure).
- With NEWTON3_EN, i of pair n equal to j of pair n+1 is fine: each cycle reads current bank.
- CLEAR lasts exactly N_ATOMS cycles; busy high same cycle-after-start through last clear cycle.
- DUMP: first beat valid the cycle after dump_start; out data/idx held stable while out_valid & !out_ready. Minimum N_ATOMS cycles with out_ready tied high.
- rst_n low mid-CLEAR/DUMP: immediate return to IDLE, all outputs and bank to reset values.

## Configuration
- NEWTON3_EN defined: reaction force (-f) applied to atom j, j range-checked, i==j rule applies.
- Undefined: only atom i updated; in_idx_j ignored (no range check, no j write); i==j pairs accumulate normally.

## Test plan
- Reset then dump with out_ready=1: 16 beats, all forces 0, out_last only on idx 15, sat_flag 0.
- NEWTON3_EN: pair i=2, j=5, fx=0x0001_8000 (1.5): dump shows acc[2].x=0x0001_8000, acc[5].x=0xFFFE_8000; without macro acc[5].x=0.
- Same pair 4 consecutive cycles, fx=0x0001_0000: acc[2].x=0x0004_0000 after, no bubbles.
- Two pairs fx=0x7000_0000 to atom 1: acc[1].x=0x7FFF_FFFF, sat_flag=1; clear_start -> 16 busy cycles, bank 0, sat_flag 0.
- Dump with out_ready toggling 1/0: each beat held stable while stalled; pair injected mid-dump dropped, drop_cnt=1, bank unchanged; in_idx_i=15 accepted, invalid index only if N_ATOMS<16.
- Assert rst_n low at dump beat 7: out_valid 0, busy 0 asynchronously; bank zeroed.
